// File: rtl/hov_run_ctrl.sv
// Hovalaag run controller: sequences CPU reset/run/stop and arbitrates
// the program-memory write port and the shared input RAM port.
module hov_run_ctrl #(
  parameter int ADDR_W = 13,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              program_set,
  input  logic              input1_set,
  input  logic              input2_set,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_prog_data,
  input  logic [11:0]       host_in_data,
  input  logic              run_req,
  input  logic              stop_req,
  input  logic [CYC_W-1:0]  cycle_limit,
  input  logic              cpu_halt,
  input  logic              cpu_in_req,
  input  logic              cpu_in_sel,
  input  logic [ADDR_W-1:0] cpu_in_addr,
  output logic              cpu_in_ack,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic              prog_we,
  output logic [7:0]        prog_waddr,
  output logic [31:0]       prog_wdata,
  output logic              inmem_en,
  output logic              inmem_we,
  output logic              inmem_sel,
  output logic [ADDR_W-1:0] inmem_addr,
  output logic [11:0]       inmem_wdata,
  output logic [1:0]        state,
  output logic [CYC_W-1:0]  cycles,
  output logic              timeout,
  output logic              write_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t stateQ, stateN;
  logic rdBusy, rdBusyN;
  logic ackN, cpuEnN, cpuRstN;
  logic progWeN;
  logic [7:0] progAddrN;
  logic [31:0] progDataN;
  logic inEnN, inWeN, inSelN;
  logic [ADDR_W-1:0] inAddrN;
  logic [11:0] inDataN;
  logic [CYC_W-1:0] cyclesN, cycInc;
  logic timeoutN, dropN;
  logic anySet, limitHit;

  assign state = stateQ;
  assign anySet = program_set | input1_set | input2_set;
  assign cycInc = cycles + 1'b1;
  assign limitHit = cpu_en && (cycle_limit != '0)
                    && (cycInc == cycle_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= IDLE;
      rdBusy      <= 1'b0;
      cpu_in_ack  <= 1'b0;
      cpu_en      <= 1'b0;
      cpu_rst     <= 1'b0;
      prog_we     <= 1'b0;
      prog_waddr  <= '0;
      prog_wdata  <= '0;
      inmem_en    <= 1'b0;
      inmem_we    <= 1'b0;
      inmem_sel   <= 1'b0;
      inmem_addr  <= '0;
      inmem_wdata <= '0;
      cycles      <= '0;
      timeout     <= 1'b0;
      write_drop  <= 1'b0;
    end else begin
      stateQ      <= stateN;
      rdBusy      <= rdBusyN;
      cpu_in_ack  <= ackN;
      cpu_en      <= cpuEnN;
      cpu_rst     <= cpuRstN;
      prog_we     <= progWeN;
      prog_waddr  <= progAddrN;
      prog_wdata  <= progDataN;
      inmem_en    <= inEnN;
      inmem_we    <= inWeN;
      inmem_sel   <= inSelN;
      inmem_addr  <= inAddrN;
      inmem_wdata <= inDataN;
      cycles      <= cyclesN;
      timeout     <= timeoutN;
      write_drop  <= dropN;
    end
  end

  always_comb begin
    stateN    = stateQ;
    rdBusyN   = 1'b0;
    ackN      = rdBusy;
    cpuEnN    = 1'b0;
    cpuRstN   = 1'b0;
    progWeN   = 1'b0;
    progAddrN = prog_waddr;
    progDataN = prog_wdata;
    inEnN     = 1'b0;
    inWeN     = 1'b0;
    inSelN    = inmem_sel;
    inAddrN   = inmem_addr;
    inDataN   = inmem_wdata;
    cyclesN   = cycles;
    timeoutN  = timeout;
    dropN     = write_drop;
    unique case (stateQ)
      IDLE, DONE: begin
        if (run_req) begin
          stateN   = RESET;
          cpuRstN  = 1'b1;
          cyclesN  = '0;
          timeoutN = 1'b0;
          dropN    = 1'b0;
        end else if (program_set) begin
          progWeN   = 1'b1;
          progAddrN = host_addr[7:0];
          progDataN = host_prog_data;
        end else if (input1_set | input2_set) begin
          inEnN   = 1'b1;
          inWeN   = 1'b1;
          inSelN  = ~input1_set;
          inAddrN = host_addr;
          inDataN = host_in_data;
        end
      end
      RESET: begin
        stateN = RUN;
        cpuEnN = 1'b1;
        if (anySet) dropN = 1'b1;
      end
      RUN: begin
        if (anySet) dropN = 1'b1;
        if (cpu_en && cycles != '1) cyclesN = cycInc;
        // a read already in flight still acks after the run ends
        if (cpu_halt || stop_req) begin
          stateN   = DONE;
          timeoutN = 1'b0;
        end else if (limitHit) begin
          stateN   = DONE;
          cyclesN  = cycle_limit;
          timeoutN = 1'b1;
        end else if (cpu_in_req && !rdBusy && !cpu_in_ack) begin
          rdBusyN = 1'b1;
          inEnN   = 1'b1;
          inSelN  = cpu_in_sel;
          inAddrN = cpu_in_addr;
        end else begin
          cpuEnN = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hov_run_ctrl.sv
// Directed bench for hov_run_ctrl: host loads, run/halt/limit/stop,
// CPU reads and reset during a read.
module tb_hov_run_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic program_set, input1_set, input2_set;
  logic [12:0] host_addr;
  logic [31:0] host_prog_data;
  logic [11:0] host_in_data;
  logic run_req, stop_req;
  logic [15:0] cycle_limit;
  logic cpu_halt, cpu_in_req, cpu_in_sel;
  logic [12:0] cpu_in_addr;
  logic cpu_in_ack, cpu_en, cpu_rst, prog_we;
  logic [7:0] prog_waddr;
  logic [31:0] prog_wdata;
  logic inmem_en, inmem_we, inmem_sel;
  logic [12:0] inmem_addr;
  logic [11:0] inmem_wdata;
  logic [1:0] state;
  logic [15:0] cycles;
  logic timeout, write_drop;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        isProg;
    logic        sel;
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];

  always #5 clk = ~clk;

  hov_run_ctrl #(.ADDR_W(13), .CYC_W(16)) dut (
    .clk(clk), .rst(rst),
    .program_set(program_set), .input1_set(input1_set),
    .input2_set(input2_set), .host_addr(host_addr),
    .host_prog_data(host_prog_data), .host_in_data(host_in_data),
    .run_req(run_req), .stop_req(stop_req),
    .cycle_limit(cycle_limit), .cpu_halt(cpu_halt),
    .cpu_in_req(cpu_in_req), .cpu_in_sel(cpu_in_sel),
    .cpu_in_addr(cpu_in_addr), .cpu_in_ack(cpu_in_ack),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .prog_we(prog_we),
    .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .inmem_en(inmem_en), .inmem_we(inmem_we),
    .inmem_sel(inmem_sel), .inmem_addr(inmem_addr),
    .inmem_wdata(inmem_wdata), .state(state), .cycles(cycles),
    .timeout(timeout), .write_drop(write_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushWr(input logic isProg, input logic sel,
                        input logic [12:0] a, input logic [31:0] d);
    wr_t w;
    w.isProg = isProg;
    w.sel = sel;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  task automatic popWr();
    wr_t w;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    w = sb.pop_front();
    if (w.isProg) begin
      chk("prog_we", 32'(prog_we), 32'd1);
      chk("prog_waddr", 32'(prog_waddr), 32'(w.addr[7:0]));
      chk("prog_wdata", prog_wdata, w.data);
      chk("prog_no_inmem", 32'(inmem_en), 32'd0);
    end else begin
      chk("inmem_en", 32'(inmem_en), 32'd1);
      chk("inmem_we", 32'(inmem_we), 32'd1);
      chk("inmem_sel", 32'(inmem_sel), 32'(w.sel));
      chk("inmem_addr", 32'(inmem_addr), 32'(w.addr));
      chk("inmem_wdata", 32'(inmem_wdata), 32'(w.data[11:0]));
      chk("inmem_no_prog", 32'(prog_we), 32'd0);
    end
  endtask

  initial begin
    int en;
    int acks;
    rst = 1'b1;
    program_set = 0; input1_set = 0; input2_set = 0;
    host_addr = '0; host_prog_data = '0; host_in_data = '0;
    run_req = 0; stop_req = 0; cycle_limit = '0;
    cpu_halt = 0; cpu_in_req = 0; cpu_in_sel = 0; cpu_in_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_inmem_en", 32'(inmem_en), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_drop", 32'(write_drop), 32'd0);

    // read request while idle is never acknowledged
    cpu_in_req = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_in_ack || inmem_en) acks++;
    end
    cpu_in_req = 0;
    chk("idle_req_noack", 32'(acks), 32'd0);

    // streaming program load
    program_set = 1;
    for (int i = 0; i < 3; i++) begin
      host_addr = 13'(16 + i);
      host_prog_data = 32'hDEADBEEF + 32'(i);
      pushWr(1'b1, 1'b0, host_addr, host_prog_data);
      tick();
      popWr();
    end
    program_set = 0;
    tick();
    chk("prog_we_off", 32'(prog_we), 32'd0);

    input2_set = 1;
    host_addr = 13'h1FFF;
    host_in_data = 12'hABC;
    pushWr(1'b0, 1'b1, host_addr, 32'h00000ABC);
    tick();
    popWr();
    input2_set = 0;
    tick();
    chk("inmem_off", 32'(inmem_en), 32'd0);

    // program beats input1 when both high
    program_set = 1;
    input1_set = 1;
    host_addr = 13'h0020;
    host_prog_data = 32'h12345678;
    host_in_data = 12'h055;
    pushWr(1'b1, 1'b0, host_addr, host_prog_data);
    tick();
    popWr();
    program_set = 0;
    host_addr = 13'h0021;
    host_in_data = 12'h066;
    pushWr(1'b0, 1'b0, host_addr, 32'h00000066);
    tick();
    popWr();
    input1_set = 0;
    tick();

    // run to halt
    cycle_limit = 16'd0;
    run_req = 1;
    tick();
    run_req = 0;
    chk("h_state_reset", 32'(state), 32'd1);
    chk("h_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("h_en_reset", 32'(cpu_en), 32'd0);
    tick();
    chk("h_state_run", 32'(state), 32'd2);
    chk("h_cpu_rst_once", 32'(cpu_rst), 32'd0);
    chk("h_en_run", 32'(cpu_en), 32'd1);
    chk("h_cycles0", 32'(cycles), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("h_cycles5", 32'(cycles), 32'd5);
    cpu_halt = 1;
    tick();
    cpu_halt = 0;
    chk("h_state_done", 32'(state), 32'd3);
    chk("h_cycles6", 32'(cycles), 32'd6);
    chk("h_timeout", 32'(timeout), 32'd0);
    chk("h_en_done", 32'(cpu_en), 32'd0);
    tick();
    chk("h_cycles_hold", 32'(cycles), 32'd6);

    // cycle limit
    cycle_limit = 16'd4;
    run_req = 1;
    tick();
    run_req = 0;
    tick();
    en = 0;
    for (int i = 0; i < 20 && state != 2'd3; i++) begin
      if (cpu_en) en++;
      tick();
    end
    chk("l_en_cycles", 32'(en), 32'd4);
    chk("l_state", 32'(state), 32'd3);
    chk("l_cycles", 32'(cycles), 32'd4);
    chk("l_timeout", 32'(timeout), 32'd1);

    // halt coinciding with the limit cycle
    run_req = 1;
    tick();
    run_req = 0;
    chk("lh_timeout_clr", 32'(timeout), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("lh_cycles3", 32'(cycles), 32'd3);
    cpu_halt = 1;
    tick();
    cpu_halt = 0;
    chk("lh_state", 32'(state), 32'd3);
    chk("lh_cycles", 32'(cycles), 32'd4);
    chk("lh_timeout", 32'(timeout), 32'd0);

    // CPU read during run
    cycle_limit = 16'd0;
    run_req = 1;
    tick();
    run_req = 0;
    tick();
    tick();
    tick();
    cpu_in_req = 1;
    cpu_in_sel = 0;
    cpu_in_addr = 13'h005;
    tick();
    chk("r_en_stall", 32'(cpu_en), 32'd0);
    chk("r_inmem_en", 32'(inmem_en), 32'd1);
    chk("r_inmem_we", 32'(inmem_we), 32'd0);
    chk("r_inmem_sel", 32'(inmem_sel), 32'd0);
    chk("r_inmem_addr", 32'(inmem_addr), 32'h005);
    chk("r_no_early_ack", 32'(cpu_in_ack), 32'd0);
    chk("r_cycles_n", 32'(cycles), 32'd3);
    tick();
    chk("r_ack", 32'(cpu_in_ack), 32'd1);
    chk("r_en_back", 32'(cpu_en), 32'd1);
    chk("r_cycles_stall", 32'(cycles), 32'd3);
    cpu_in_req = 0;
    tick();
    chk("r_ack_off", 32'(cpu_in_ack), 32'd0);
    chk("r_cycles_go", 32'(cycles), 32'd4);
    stop_req = 1;
    tick();
    stop_req = 0;
    chk("s_state", 32'(state), 32'd3);
    chk("s_timeout", 32'(timeout), 32'd0);

    // host write during run is dropped and flagged
    run_req = 1;
    tick();
    run_req = 0;
    tick();
    program_set = 1;
    host_addr = 13'h0030;
    tick();
    program_set = 0;
    chk("d_no_we", 32'(prog_we), 32'd0);
    chk("d_flag", 32'(write_drop), 32'd1);
    stop_req = 1;
    tick();
    stop_req = 0;
    chk("d_flag_hold", 32'(write_drop), 32'd1);
    run_req = 1;
    tick();
    run_req = 0;
    chk("d_flag_clr", 32'(write_drop), 32'd0);
    tick();

    // reset with a read outstanding
    cpu_in_req = 1;
    cpu_in_sel = 1;
    cpu_in_addr = 13'h007;
    tick();
    chk("x_read_issued", 32'(inmem_en), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    cpu_in_req = 0;
    chk("x_state", 32'(state), 32'd0);
    chk("x_cpu_en", 32'(cpu_en), 32'd0);
    chk("x_ack", 32'(cpu_in_ack), 32'd0);
    chk("x_cycles", 32'(cycles), 32'd0);
    chk("x_inmem", 32'(inmem_en), 32'd0);
    tick();
    chk("x_ack_after", 32'(cpu_in_ack), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hov_run_ctrl.md
Name: hov_run_ctrl

Overview:
- Run controller and memory-port arbiter for the Hovalaag CPU.
- Accepts host load strobes from the USB/EPP register interface and sequences CPU reset, run and stop.
- Owns the single write port of program memory and the single port of the shared input RAM (bank 0 = input 1, bank 1 = input 2).
- Grants the input RAM port to the host when the CPU is not running, and to CPU input reads while it is.

Parameters:
ADDR_W, 13, input RAM address width per bank
CYC_W, 16, cycle counter and cycle limit width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
program_set  in  1  host: write program word (level; one write per cycle while high)
input1_set  in  1  host: write input bank 0 (level)
input2_set  in  1  host: write input bank 1 (level)
host_addr  in  ADDR_W  host address; program uses [7:0]
host_prog_data  in  32  host program word
host_in_data  in  12  host input word
run_req  in  1  start-run pulse
stop_req  in  1  abort-run pulse
cycle_limit  in  CYC_W  max CPU cycles; 0 = unlimited
cpu_halt  in  1  CPU executed halt
cpu_in_req  in  1  CPU input read request (level until ack)
cpu_in_sel  in  1  CPU read bank
cpu_in_addr  in  ADDR_W  CPU read address
cpu_in_ack  out  1  read data valid on RAM output this cycle
cpu_en  out  1  CPU clock enable
cpu_rst  out  1  CPU reset pulse
prog_we  out  1  program memory write enable
prog_waddr  out  8  program memory address
prog_wdata  out  32  program memory data
inmem_en  out  1  input RAM enable
inmem_we  out  1  input RAM write enable
inmem_sel  out  1  input RAM bank
inmem_addr  out  ADDR_W  input RAM address
inmem_wdata  out  12  input RAM write data
state  out  2  0 IDLE, 1 RESET, 2 RUN, 3 DONE
cycles  out  CYC_W  CPU-enabled cycles in current/last run
timeout  out  1  last run ended on cycle limit
write_drop  out  1  sticky: host write attempted during RESET/RUN

Behaviour:
- Reset values: state=IDLE; all outputs 0; cycles=0.
- rst at any time, including mid-run or mid-read: all outputs return to reset values at the next edge. Any read in flight is abandoned with no ack.
- All outputs are registered.
- Host writes, IDLE or DONE only:
  - A set sampled high at edge N gives a one-cycle write at N+1, with address and data captured at N.
  - prog_we is active on a program_set write; inmem_en=inmem_we=1 with inmem_sel=0/1 on an input1_set/input2_set write.
  - If several sets are high in one cycle, priority is program > input1 > input2; the others are dropped with no flag.
  - A held set writes every cycle, so streaming fill is supported.
- Host writes in RESET or RUN: ignored, and write_drop is set.
- FSM transitions:
  - IDLE or DONE, run_req=1 -> RESET. At the same edge: cycles=0, timeout=0, write_drop=0. A host set in that same cycle is dropped.
  - RESET: cpu_rst=1 for exactly 1 cycle; cpu_en=0; next state RUN.
  - RUN: cpu_en = 1 except while a CPU read is outstanding. cycles increments by 1 on every cycle that cpu_en=1.
  - RUN exits to DONE on any of:
    - cpu_halt=1: timeout=0.
    - stop_req=1: timeout=0.
    - cycle_limit!=0 and cycles+1==cycle_limit on a cpu_en cycle: cycles becomes cycle_limit, timeout=1.
  - Simultaneous exit conditions: halt > stop > limit. Any halt or stop present forces timeout=0.
  - DONE: cpu_en=0; cycles and timeout hold.
  - run_req in RESET or RUN: ignored. stop_req outside RUN: ignored.
- cycles saturates at all-ones when cycle_limit=0.
- CPU reads, RUN only:
  - cpu_in_req sampled at edge N: cpu_en=0 from N+1, and inmem_en=1, we=0, sel/addr from the CPU at N+1. cpu_in_ack=1 and cpu_en=1 at N+2. Read latency is 2 cycles; cpu_en low for 1 cycle.
  - The CPU deasserts req when it sees ack. A req still high on the ack cycle is not re-issued until the following cycle.
  - cpu_in_req outside RUN: never acked.
  - Run ending with a read in flight (halt or stop) completes the ack but keeps cpu_en=0.

Test Plan:
- Host load: program_set high 3 cycles, host_addr 0x10..0x12, data 0xDEADBEEF.. -> prog_we high 3 cycles, each one cycle late, waddr 0x10/0x11/0x12 with matching data; input2_set addr 0x1FFF data 0xABC -> inmem_we=1, sel=1, addr 0x1FFF, wdata 0xABC.
- Run to halt: cycle_limit=0, run_req, cpu_halt after 5 enabled cycles -> state 0,1,2,…,3; cpu_rst a single cycle; cycles=5 at halt edge, then 6 after that edge (halt cycle counted); timeout=0.
- Cycle limit: cycle_limit=4, no halt -> exactly 4 cpu_en cycles, cycles=4, timeout=1, DONE; simultaneous halt on the 4th cycle -> timeout=0.
- CPU read: in RUN, cpu_in_req sel=0 addr 0x005 -> inmem_en at N+1, ack at N+2, cpu_en low 1 cycle, cycles not advanced during the stall; cpu_in_req in IDLE -> no ack ever.
- Write during run: program_set during RUN -> no prog_we, write_drop=1; next run_req clears it.
- rst asserted mid-RUN with a read outstanding -> next edge state=0, cpu_en=0, no ack, cycles=0.
